// File: rtl/wt_dcache_rd_arb.sv
// Purpose: N-port read arbiter between the L1 read ports and the cache array, with two priority classes and a starvation guard.
// Latency: grant is combinational (0 cycles); rd_rvalid_o follows the ack by exactly 1 cycle.
// Backpressure: stall_i or mem_gnt_i low withholds acks; requesters hold rd_req_i until acked.
module wt_dcache_rd_arb #(
    parameter int NumPorts = 3,
    parameter int TagW     = 44,
    parameter int IdxW     = 8,
    parameter int OffW     = 4,
    parameter int DataW    = 64,
    parameter int MaxStall = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           stall_i,
    input  logic [NumPorts-1:0]            rd_prio_i,
    input  logic [NumPorts-1:0]            rd_req_i,
    input  logic [NumPorts-1:0]            rd_tag_only_i,
    input  logic [NumPorts-1:0][TagW-1:0]  rd_tag_i,
    input  logic [NumPorts-1:0][IdxW-1:0]  rd_idx_i,
    input  logic [NumPorts-1:0][OffW-1:0]  rd_off_i,
    output logic [NumPorts-1:0]            rd_ack_o,
    output logic [NumPorts-1:0]            rd_rvalid_o,
    output logic [DataW-1:0]               rd_data_o,
    output logic                           mem_req_o,
    input  logic                           mem_gnt_i,
    output logic [TagW-1:0]                mem_tag_o,
    output logic [IdxW-1:0]                mem_idx_o,
    output logic [OffW-1:0]                mem_off_o,
    output logic                           mem_tag_only_o,
    input  logic [DataW-1:0]               mem_rdata_i,
    output logic                           busy_o
);

    localparam int PtrW = $clog2(NumPorts);
    // A zero-width counter is not legal, so keep one bit when promotion is disabled.
    localparam int CntW = (MaxStall > 0) ? $clog2(MaxStall + 1) : 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxStall);

    logic [NumPorts-1:0] hi_req;
    logic [NumPorts-1:0] lo_req;
    logic [NumPorts-1:0] cls_req;
    logic [NumPorts-1:0] sel_oh;
    logic [NumPorts-1:0] resp_q;
    logic [PtrW-1:0]     ptr_hi;
    logic [PtrW-1:0]     ptr_lo;
    logic [PtrW-1:0]     scan_ptr;
    logic [PtrW-1:0]     cand;
    logic [PtrW-1:0]     sel_idx;
    logic [PtrW-1:0]     ptr_nxt;
    logic [CntW-1:0]     starve_cnt;
    logic                promote;
    logic                sel_lo;
    logic                found;
    logic                grant;

    // (base + off) mod NumPorts; off never exceeds NumPorts so one subtraction suffices.
    function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NumPorts) begin
            s = s - NumPorts;
        end
        return PtrW'(s);
    endfunction

    assign hi_req = rd_req_i & rd_prio_i;
    assign lo_req = rd_req_i & ~rd_prio_i;

    // Low class wins when starved long enough, or when no high-priority port is asking.
    assign promote  = (MaxStall != 0) && (|lo_req) && (starve_cnt == MaxCnt);
    assign sel_lo   = promote || !(|hi_req);
    assign cls_req  = sel_lo ? lo_req : hi_req;
    assign scan_ptr = sel_lo ? ptr_lo : ptr_hi;

    // Round-robin scan: first requester of the chosen class at or after its pointer.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int i = 0; i < NumPorts; i++) begin
            cand = wrap_add(scan_ptr, i);
            if (!found && cls_req[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign sel_oh  = found ? (NumPorts'(1) << sel_idx) : '0;
    assign ptr_nxt = wrap_add(sel_idx, 1);

    // rst_ni gates the request so nothing is granted while reset is held.
    assign mem_req_o      = (|rd_req_i) & ~stall_i & rst_ni;
    assign grant          = mem_req_o & mem_gnt_i;
    assign rd_ack_o       = sel_oh & {NumPorts{grant}};
    assign mem_tag_o      = rd_tag_i[sel_idx];
    assign mem_idx_o      = rd_idx_i[sel_idx];
    assign mem_off_o      = rd_off_i[sel_idx];
    assign mem_tag_only_o = rd_tag_only_i[sel_idx];

    // Advance only the pointer of the class that actually won an accepted grant.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_hi <= '0;
            ptr_lo <= '0;
        end else if (grant) begin
            if (sel_lo) begin
                ptr_lo <= ptr_nxt;
            end else begin
                ptr_hi <= ptr_nxt;
            end
        end
    end

    // Count cycles a low-priority request waits; collisions count, stalls do not.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (grant && sel_lo) begin
            starve_cnt <= '0;
        end else if ((|lo_req) && !stall_i && (starve_cnt != MaxCnt)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Remember who was granted so the array data one cycle later is tagged for them.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_q <= '0;
        end else begin
            resp_q <= rd_ack_o;
        end
    end

    assign rd_rvalid_o = resp_q;
    assign rd_data_o   = mem_rdata_i;
    assign busy_o      = (|rd_req_i) | (|resp_q);

    // A requester must keep asking until it has been acknowledged.
    for (genvar p = 0; p < NumPorts; p++) begin : g_req_hold
        a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (rd_req_i[p] && !rd_ack_o[p]) |=> rd_req_i[p]);
    end

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
module tb_wt_dcache_rd_arb;

    localparam int TW = 44;
    localparam int IW = 8;
    localparam int OW = 4;
    localparam int DW = 64;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          stall     = 1'b0;
    logic          mem_gnt   = 1'b1;
    logic [DW-1:0] mem_rdata = '0;

    // three-port instance, starvation limit 4
    logic [2:0]         a_prio = '0, a_req = '0, a_tag_only = '0;
    logic [2:0][TW-1:0] a_tag;
    logic [2:0][IW-1:0] a_idx;
    logic [2:0][OW-1:0] a_off;
    logic [2:0]         a_ack, a_rvalid;
    logic [DW-1:0]      a_rdata;
    logic               a_mem_req, a_mem_tag_only, a_busy;
    logic [TW-1:0]      a_mem_tag;
    logic [IW-1:0]      a_mem_idx;
    logic [OW-1:0]      a_mem_off;

    // five-port instance, promotion disabled
    logic [4:0]         b_prio = '0, b_req = '0, b_tag_only = '0;
    logic [4:0][TW-1:0] b_tag;
    logic [4:0][IW-1:0] b_idx;
    logic [4:0][OW-1:0] b_off;
    logic [4:0]         b_ack, b_rvalid;
    logic [DW-1:0]      b_rdata;
    logic               b_mem_req, b_mem_tag_only, b_busy;
    logic [TW-1:0]      b_mem_tag;
    logic [IW-1:0]      b_mem_idx;
    logic [OW-1:0]      b_mem_off;

    int checks   = 0;
    int failures = 0;

    logic [2:0] starve_exp [10] = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b100,
                                    3'b001, 3'b010, 3'b001, 3'b010, 3'b100};

    always #5 clk = ~clk;

    wt_dcache_rd_arb #(.NumPorts(3), .TagW(TW), .IdxW(IW), .OffW(OW), .DataW(DW), .MaxStall(4)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
        .rd_prio_i(a_prio), .rd_req_i(a_req), .rd_tag_only_i(a_tag_only),
        .rd_tag_i(a_tag), .rd_idx_i(a_idx), .rd_off_i(a_off),
        .rd_ack_o(a_ack), .rd_rvalid_o(a_rvalid), .rd_data_o(a_rdata),
        .mem_req_o(a_mem_req), .mem_gnt_i(mem_gnt),
        .mem_tag_o(a_mem_tag), .mem_idx_o(a_mem_idx), .mem_off_o(a_mem_off),
        .mem_tag_only_o(a_mem_tag_only), .mem_rdata_i(mem_rdata), .busy_o(a_busy)
    );

    wt_dcache_rd_arb #(.NumPorts(5), .TagW(TW), .IdxW(IW), .OffW(OW), .DataW(DW), .MaxStall(0)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
        .rd_prio_i(b_prio), .rd_req_i(b_req), .rd_tag_only_i(b_tag_only),
        .rd_tag_i(b_tag), .rd_idx_i(b_idx), .rd_off_i(b_off),
        .rd_ack_o(b_ack), .rd_rvalid_o(b_rvalid), .rd_data_o(b_rdata),
        .mem_req_o(b_mem_req), .mem_gnt_i(mem_gnt),
        .mem_tag_o(b_mem_tag), .mem_idx_o(b_mem_idx), .mem_off_o(b_mem_off),
        .mem_tag_only_o(b_mem_tag_only), .mem_rdata_i(mem_rdata), .busy_o(b_busy)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reset is raised with requests still held, requests drop inside reset, then release.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        a_req = '0; b_req = '0; a_tag_only = '0; b_tag_only = '0;
        stall = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int p = 0; p < 3; p++) begin
            a_tag[p] = TW'(44'h0AB_0000_0100 + p);
            a_idx[p] = IW'(8'h10 + p);
            a_off[p] = OW'(p);
        end
        for (int p = 0; p < 5; p++) begin
            b_tag[p] = TW'(44'h0CD_0000_0200 + p);
            b_idx[p] = IW'(8'h20 + p);
            b_off[p] = OW'(p);
        end

        // reset state: requests present but reset held
        @(negedge clk);
        a_prio = 3'b011; a_req = 3'b011;
        #1;
        check_val("rst_mem_req", 64'(a_mem_req), 64'd0);
        check_val("rst_ack", 64'(a_ack), 64'd0);
        @(negedge clk);
        #1;
        check_val("rst_rvalid", 64'(a_rvalid), 64'd0);
        check_val("rst_ptr_hi", 64'(u_dut_a.ptr_hi), 64'd0);
        do_reset();
        #1;
        check_val("rst_busy", 64'(a_busy), 64'd0);

        // round-robin between two high-priority ports
        a_prio = 3'b011; a_req = 3'b011;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_val($sformatf("rr_ack%0d", k), 64'(a_ack), (k % 2 == 0) ? 64'd1 : 64'd2);
            check_val($sformatf("rr_idx%0d", k), 64'(a_mem_idx), (k % 2 == 0) ? 64'h10 : 64'h11);
            check_val($sformatf("rr_rvalid%0d", k), 64'(a_rvalid),
                      (k == 0) ? 64'd0 : ((k % 2 == 1) ? 64'd1 : 64'd2));
            @(negedge clk);
        end

        // starvation guard, limit 4: port 2 wins every 5th cycle
        do_reset();
        a_prio = 3'b011; a_req = 3'b111;
        for (int k = 0; k < 10; k++) begin
            #1;
            check_val($sformatf("starve_ack%0d", k), 64'(a_ack), 64'(starve_exp[k]));
            check_val($sformatf("starve_cnt%0d", k), 64'(u_dut_a.starve_cnt), 64'(k % 5));
            @(negedge clk);
        end

        // stall holds the starvation count and blocks grants; responses still drain
        do_reset();
        a_prio = 3'b011; a_req = 3'b111;
        #1; check_val("stl_ack0", 64'(a_ack), 64'd1);
        @(negedge clk);
        #1; check_val("stl_ack1", 64'(a_ack), 64'd2);
        @(negedge clk);
        stall = 1'b1;
        #1;
        check_val("stl_mem_req", 64'(a_mem_req), 64'd0);
        check_val("stl_ack_blk", 64'(a_ack), 64'd0);
        check_val("stl_drain", 64'(a_rvalid), 64'd2);
        check_val("stl_cnt_a", 64'(u_dut_a.starve_cnt), 64'd2);
        @(negedge clk);
        #1;
        check_val("stl_rvalid0", 64'(a_rvalid), 64'd0);
        check_val("stl_cnt_b", 64'(u_dut_a.starve_cnt), 64'd2);
        @(negedge clk);
        stall = 1'b0;
        #1; check_val("stl_ack2", 64'(a_ack), 64'd1);
        @(negedge clk);
        #1; check_val("stl_ack3", 64'(a_ack), 64'd2);
        @(negedge clk);
        #1; check_val("stl_ack_lo", 64'(a_ack), 64'd4);
        @(negedge clk);

        // reset the cycle after an ack: response is discarded
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ack", 64'(a_ack), 64'd0);
        check_val("mid_rst_mem_req", 64'(a_mem_req), 64'd0);
        @(negedge clk);
        a_req = '0;
        #1;
        check_val("mid_rst_rvalid", 64'(a_rvalid), 64'd0);
        check_val("mid_rst_ptr_hi", 64'(u_dut_a.ptr_hi), 64'd0);
        check_val("mid_rst_ptr_lo", 64'(u_dut_a.ptr_lo), 64'd0);
        check_val("mid_rst_cnt", 64'(u_dut_a.starve_cnt), 64'd0);
        check_val("mid_rst_busy", 64'(a_busy), 64'd0);
        do_reset();

        // collision: array refuses for three cycles, then accepts
        a_prio = 3'b011; a_req = 3'b010; a_tag_only = 3'b010;
        mem_gnt = 1'b0; mem_rdata = 64'hDEADBEEF_CAFEF00D;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val($sformatf("col_ack%0d", k), 64'(a_ack), 64'd0);
            check_val($sformatf("col_req%0d", k), 64'(a_mem_req), 64'd1);
            check_val($sformatf("col_ptr%0d", k), 64'(u_dut_a.ptr_hi), 64'd0);
            @(negedge clk);
        end
        mem_gnt = 1'b1;
        #1;
        check_val("col_ack", 64'(a_ack), 64'd2);
        check_val("col_tag", 64'(a_mem_tag), 64'h0AB_0000_0101);
        check_val("col_off", 64'(a_mem_off), 64'd1);
        check_val("col_tag_only", 64'(a_mem_tag_only), 64'd1);
        @(negedge clk);
        a_req = '0; a_tag_only = '0;
        #1;
        check_val("col_rvalid", 64'(a_rvalid), 64'd2);
        check_val("col_data", a_rdata, 64'hDEADBEEF_CAFEF00D);
        check_val("col_busy", 64'(a_busy), 64'd1);
        check_val("col_ptr_after", 64'(u_dut_a.ptr_hi), 64'd2);
        @(negedge clk);
        #1;
        check_val("col_idle_rvalid", 64'(a_rvalid), 64'd0);
        check_val("col_idle_busy", 64'(a_busy), 64'd0);

        // strict priority with promotion disabled: low port waits for the high class to empty
        do_reset();
        b_prio = 5'b00011; b_req = 5'b00111;
        for (int k = 0; k < 10; k++) begin
            #1;
            check_val($sformatf("pri_ack%0d", k), 64'(b_ack), (k % 2 == 0) ? 64'd1 : 64'd2);
            @(negedge clk);
        end
        b_req = 5'b00101;
        #1; check_val("pri_last_hi", 64'(b_ack), 64'd1);
        @(negedge clk);
        b_req = 5'b00100;
        #1; check_val("pri_lo_ack", 64'(b_ack), 64'd4);
        @(negedge clk);
        b_req = '0;
        #1; check_val("pri_lo_rvalid", 64'(b_rvalid), 64'd4);
        @(negedge clk);

        // pointer wrap across five ports
        do_reset();
        b_prio = 5'b11111; b_req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_val($sformatf("wrap_ack%0d", k), 64'(b_ack), 64'd1 << (k % 5));
            check_val($sformatf("wrap_ptr%0d", k), 64'(u_dut_b.ptr_hi), 64'(k % 5));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
